// File: rtl/pipeline_ex_muldiv.sv
// Execute-stage multiply/divide unit for the RV M extension.
// Multiplies complete after a fixed latency. Divides use a restoring loop
// that produces one quotient bit per cycle. Divide-by-zero and signed
// overflow skip the loop and finish one cycle after acceptance.
module pipeline_ex_muldiv #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            valid_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] val1_i,
  input  logic [XLEN-1:0] val2_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [4:0]      rd_o,
  output logic            we_o,
  output logic [XLEN-1:0] wdata_o
);

  localparam int unsigned     CntW   = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic [4:0]        rd_out_q, rd_out_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;

  // ---------------------------------------------------------------------------
  // Multiplier. Operands come straight from the inputs in the accept cycle so
  // that a single-cycle multiply can finish without a register stage.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0]   mul_a, mul_b;
  logic [2:0]        mul_op;
  logic              mul_sa, mul_sb;
  logic [2*XLEN-1:0] mul_a_ext, mul_b_ext, mul_prod;
  logic [XLEN-1:0]   mul_res;

  assign mul_a  = (state_q == StIdle) ? val1_i : a_q;
  assign mul_b  = (state_q == StIdle) ? val2_i : b_q;
  assign mul_op = (state_q == StIdle) ? op_i   : op_q;

  // MULH: both signed. MULHSU: only rs1 signed. MULHU and MUL: unsigned is fine.
  assign mul_sa = (mul_op == 3'd1) || (mul_op == 3'd2);
  assign mul_sb = (mul_op == 3'd1);

  // Both operands are sign/zero extended to 2*XLEN. The low 2*XLEN bits of the
  // product are then exact for every signedness mix.
  assign mul_a_ext = {{XLEN{mul_sa & mul_a[XLEN-1]}}, mul_a};
  assign mul_b_ext = {{XLEN{mul_sb & mul_b[XLEN-1]}}, mul_b};
  assign mul_prod  = mul_a_ext * mul_b_ext;
  assign mul_res   = (mul_op[1:0] == 2'd0) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

  // ---------------------------------------------------------------------------
  // Divider set-up (decoded from the inputs at acceptance).
  // ---------------------------------------------------------------------------
  logic            in_signed, in_neg1, in_neg2;
  logic [XLEN-1:0] in_abs1, in_abs2;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] bypass_res;

  assign in_signed = ~op_i[0];
  assign in_neg1   = in_signed & val1_i[XLEN-1];
  assign in_neg2   = in_signed & val2_i[XLEN-1];
  assign in_abs1   = in_neg1 ? -val1_i : val1_i;
  assign in_abs2   = in_neg2 ? -val2_i : val2_i;
  assign div_zero  = (val2_i == '0);
  assign div_ovf   = in_signed & (val1_i == MinNeg) & (&val2_i);

  // Divide by zero: quotient all ones, remainder = dividend.
  // Overflow: quotient = most-negative (the dividend itself), remainder 0.
  assign bypass_res = div_zero ? (op_i[1] ? val1_i : '1)
                               : (op_i[1] ? '0 : MinNeg);

  // ---------------------------------------------------------------------------
  // Restoring divide step. {rem, quo} shifts left one bit per cycle.
  // ---------------------------------------------------------------------------
  logic [XLEN:0]   div_sh;
  logic            div_ge;
  logic [XLEN-1:0] rem_nxt, quo_nxt, div_res;

  assign div_sh  = {rem_q, quo_q[XLEN-1]};
  assign div_ge  = (div_sh >= {1'b0, dvs_q});
  // When div_ge holds, the difference is below dvs_q, so XLEN bits are enough.
  assign rem_nxt = div_ge ? (div_sh[XLEN-1:0] - dvs_q) : div_sh[XLEN-1:0];
  assign quo_nxt = {quo_q[XLEN-2:0], div_ge};
  assign div_res = op_q[1] ? (rneg_q ? -rem_nxt : rem_nxt)
                           : (qneg_q ? -quo_nxt : quo_nxt);

  // ---------------------------------------------------------------------------
  // Outputs. A flush in the DONE cycle hides the result.
  // ---------------------------------------------------------------------------
  assign done_o  = (state_q == StDone) & ~flush_i;
  assign we_o    = done_o & (rd_out_q != 5'd0);
  assign rd_o    = rd_out_q;
  assign wdata_o = wdata_q;
  assign stall_o = valid_i & ~done_o & ~flush_i;

  // Next-state and datapath update. Flush wins over rdy. rdy low freezes everything.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    rd_out_d = rd_out_q;
    wdata_d  = wdata_q;

    if (flush_i) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (rdy) begin
      case (state_q)
        StIdle: begin
          if (valid_i) begin
            op_d   = op_i;
            rd_d   = rd_i;
            a_d    = val1_i;
            b_d    = val2_i;
            cnt_d  = '0;
            if (!op_i[2]) begin
              if (MUL_CYCLES == 1) begin
                state_d  = StDone;
                rd_out_d = rd_i;
                wdata_d  = mul_res;
              end else begin
                state_d = StMul;
                cnt_d   = CntW'(1);
              end
            end else if (div_zero || div_ovf) begin
              state_d  = StDone;
              rd_out_d = rd_i;
              wdata_d  = bypass_res;
            end else begin
              state_d = StDiv;
              rem_d   = '0;
              quo_d   = in_abs1;
              dvs_d   = in_abs2;
              qneg_d  = in_neg1 ^ in_neg2;
              rneg_d  = in_neg1;
            end
          end
        end
        StMul: begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(MUL_CYCLES - 1)) begin
            state_d  = StDone;
            rd_out_d = rd_q;
            wdata_d  = mul_res;
          end
        end
        StDiv: begin
          cnt_d = cnt_q + CntW'(1);
          rem_d = rem_nxt;
          quo_d = quo_nxt;
          if (cnt_q == CntW'(XLEN - 1)) begin
            state_d  = StDone;
            rd_out_d = rd_q;
            wdata_d  = div_res;
          end
        end
        StDone: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      rd_out_q <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      rd_out_q <= rd_out_d;
      wdata_q  <= wdata_d;
    end
  end

endmodule

// File: tb/tb_pipeline_ex_muldiv.sv
// Self-checking bench for pipeline_ex_muldiv (XLEN=32, MUL_CYCLES=2).
// Directed cases cover the listed corner values. Random operations are
// compared against an arithmetic reference model.
module tb_pipeline_ex_muldiv;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            rdy;
  logic            valid_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] val1_i;
  logic [XLEN-1:0] val2_i;
  logic [4:0]      rd_i;
  logic            flush_i;
  logic            stall_o;
  logic            done_o;
  logic [4:0]      rd_o;
  logic            we_o;
  logic [XLEN-1:0] wdata_o;

  int n_cmp = 0;
  int n_err = 0;

  pipeline_ex_muldiv #(
    .XLEN       (32),
    .MUL_CYCLES (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rdy     (rdy),
    .valid_i (valid_i),
    .op_i    (op_i),
    .val1_i  (val1_i),
    .val2_i  (val2_i),
    .rd_i    (rd_i),
    .flush_i (flush_i),
    .stall_o (stall_o),
    .done_o  (done_o),
    .rd_o    (rd_o),
    .we_o    (we_o),
    .wdata_o (wdata_o)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference results from plain integer arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (!op[2]) return 2;
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Issue one operation, optionally pulling rdy low for stall_len cycles
  // starting at cycle stall_at, and check the result and its timing.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat,
                        input int stall_at, input int stall_len);
    int n;
    bit seen;
    @(posedge clk); #1;
    valid_i = 1'b1;
    op_i    = op;
    val1_i  = a;
    val2_i  = b;
    rd_i    = rd;
    @(negedge clk);
    check_eq({tag, "/stall0"}, 64'(stall_o), 64'd1);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        // Operands must have been captured at acceptance.
        val1_i = $urandom;
        val2_i = $urandom;
      end
      @(negedge clk);
      if (done_o) begin
        seen = 1'b1;
      end else if (stall_len > 0) begin
        if (n == stall_at) rdy = 1'b0;
        if (n == stall_at + stall_len) rdy = 1'b1;
      end
    end
    check_eq({tag, "/done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      check_eq({tag, "/latency"}, 64'(n), 64'(exp_lat));
      check_eq({tag, "/wdata"}, 64'(wdata_o), 64'(exp_res));
      check_eq({tag, "/rd"}, 64'(rd_o), 64'(rd));
      check_eq({tag, "/we"}, 64'(we_o), 64'(rd != 5'd0));
      check_eq({tag, "/stall_done"}, 64'(stall_o), 64'd0);
    end
    valid_i = 1'b0;
    rdy     = 1'b1;
  endtask

  initial begin
    int          seen_done;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [4:0]  rd;
    int          lat, s_at, s_len;

    rst     = 1'b0;
    rdy     = 1'b1;
    valid_i = 1'b0;
    op_i    = '0;
    val1_i  = '0;
    val2_i  = '0;
    rd_i    = '0;
    flush_i = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset/done", 64'(done_o), 64'd0);
    check_eq("reset/we", 64'(we_o), 64'd0);
    check_eq("reset/rd", 64'(rd_o), 64'd0);
    check_eq("reset/wdata", 64'(wdata_o), 64'd0);
    check_eq("reset/stall", 64'(stall_o), 64'd0);
    rst = 1'b1;

    // Directed values.
    run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 2, 0, 0);
    @(negedge clk);
    check_eq("hold/done", 64'(done_o), 64'd0);
    check_eq("hold/wdata", 64'(wdata_o), 64'hFFFF_FFEB);
    run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, 2, 0, 0);
    run_op("div", 3'd4, 32'hFFFF_FFEC, 32'd3, 5'd7, 32'hFFFF_FFFA, 33, 0, 0);
    run_op("rem", 3'd6, 32'hFFFF_FFEC, 32'd3, 5'd8, 32'hFFFF_FFFE, 33, 0, 0);
    run_op("divu", 3'd5, 32'd100, 32'd7, 5'd9, 32'd14, 33, 0, 0);
    run_op("divu0", 3'd5, 32'h1234, 32'd0, 5'd10, 32'hFFFF_FFFF, 1, 0, 0);
    run_op("rem0", 3'd6, 32'h1234, 32'd0, 5'd11, 32'h1234, 1, 0, 0);
    run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1, 0, 0);
    run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0, 1, 0, 0);
    run_op("rdy_gap", 3'd4, 32'hFFFF_FFEC, 32'd3, 5'd14, 32'hFFFF_FFFA, 38, 10, 5);
    run_op("rd0", 3'd0, 32'd3, 32'd4, 5'd0, 32'd12, 2, 0, 0);

    // Flush in cycle 10 of a divide.
    @(posedge clk); #1;
    valid_i = 1'b1; op_i = 3'd4; val1_i = 32'd1000; val2_i = 32'd7; rd_i = 5'd3;
    @(negedge clk);
    for (int n = 1; n <= 10; n++) @(negedge clk);
    flush_i = 1'b1;
    #1;
    check_eq("flush/stall", 64'(stall_o), 64'd0);
    check_eq("flush/done", 64'(done_o), 64'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    seen_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) seen_done++;
    end
    check_eq("flush/no_done", 64'(seen_done), 64'd0);
    run_op("after_flush", 3'd0, 32'd6, 32'd9, 5'd4, 32'd54, 2, 0, 0);

    // Flush coincident with DONE hides done_o and we_o.
    @(posedge clk); #1;
    valid_i = 1'b1; op_i = 3'd0; val1_i = 32'd3; val2_i = 32'd5; rd_i = 5'd9;
    @(posedge clk);
    @(posedge clk); #1;
    flush_i = 1'b1;
    #1;
    check_eq("flush_done/done", 64'(done_o), 64'd0);
    check_eq("flush_done/we", 64'(we_o), 64'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    @(negedge clk);
    check_eq("flush_done/after", 64'(done_o), 64'd0);

    // Reset in the middle of a multiply clears every output at once.
    run_op("pre_rst", 3'd0, 32'h1234, 32'h10, 5'd7, 32'h12340, 2, 0, 0);
    @(posedge clk); #1;
    valid_i = 1'b1; op_i = 3'd0; val1_i = 32'd11; val2_i = 32'd13; rd_i = 5'd17;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_mid/done", 64'(done_o), 64'd0);
    check_eq("rst_mid/we", 64'(we_o), 64'd0);
    check_eq("rst_mid/rd", 64'(rd_o), 64'd0);
    check_eq("rst_mid/wdata", 64'(wdata_o), 64'd0);
    valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_op("post_rst", 3'd4, 32'hFFFF_FF9C, 32'd10, 5'd2, 32'hFFFF_FFF6, 33, 0, 0);

    // Random operations against the reference model.
    for (int i = 0; i < 150; i++) begin
      op    = 3'($urandom_range(0, 7));
      a     = pick_operand();
      b     = pick_operand();
      rd    = 5'($urandom_range(0, 31));
      lat   = ref_latency(op, a, b);
      s_at  = 0;
      s_len = 0;
      if (lat >= 2 && $urandom_range(0, 3) == 0) begin
        s_at  = $urandom_range(1, lat - 1);
        s_len = $urandom_range(1, 4);
      end
      run_op($sformatf("rand%0d_op%0d", i, op), op, a, b, rd, ref_result(op, a, b),
             lat + s_len, s_at, s_len);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_ex_muldiv.md
PIPELINE_EX_MULDIV -- requirements
Module: pipeline_ex_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving operand and result width (legal values 32 and 64).
REQ-002 SHALL have parameter MUL_CYCLES, default 2, giving multiply latency in cycles (legal range 1..4).
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port rdy, input, 1 bit: global ready; when low, all state freezes.
REQ-006 SHALL have port valid_i, input, 1 bit: an M-extension instruction is present.
REQ-007 SHALL have port op_i, input, 3 bits: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 SHALL have ports val1_i and val2_i, input, XLEN bits each: forwarded rs1 and rs2 operands.
REQ-009 SHALL have port rd_i, input, 5 bits: destination register.
REQ-010 SHALL have port flush_i, input, 1 bit: abort the in-flight operation (branch redirect).
REQ-011 SHALL have port stall_o, output, 1 bit: upstream holds the instruction while high.
REQ-012 SHALL have port done_o, output, 1 bit: one-cycle result-valid pulse.
REQ-013 SHALL have ports rd_o (output, 5 bits), we_o (output, 1 bit) and wdata_o (output, XLEN bits): writeback to the MEM stage.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, DIV, DONE; on reset the state SHALL be IDLE.
REQ-015 SHALL accept an operation when state is IDLE, valid_i=1, rdy=1 and flush_i=0; operands, op and rd SHALL be captured at acceptance (cycle 0).
REQ-016 SHALL drive stall_o = valid_i AND NOT done_o AND NOT flush_i, combinationally.
REQ-017 Multiply (ops 0-3) SHALL run in state MUL for MUL_CYCLES rdy-high cycles, then enter DONE; done_o SHALL be high in cycle MUL_CYCLES.
REQ-018 MUL SHALL return the low XLEN bits of the product; MULH, MULHSU and MULHU SHALL return the high XLEN bits of the 2*XLEN product under signed x signed, signed x unsigned and unsigned x unsigned interpretation respectively.
REQ-019 Divide (ops 4-7) SHALL use a restoring algorithm producing 1 quotient bit per cycle on magnitudes, with XLEN iterations; done_o SHALL be high in cycle XLEN+1.
REQ-020 Signed results SHALL set the quotient sign to sign1 XOR sign2 and the remainder sign to the sign of the dividend.
REQ-021 Divide by zero SHALL bypass iteration with done_o in cycle 1: quotient all ones; remainder equal to the dividend.
REQ-022 Signed overflow (most-negative divided by -1) SHALL bypass iteration with done_o in cycle 1: quotient most-negative; remainder 0.
REQ-023 In DONE, the block SHALL assert done_o and we_o = (rd != 0), drive rd_o and wdata_o, return to IDLE next cycle, and not accept an operation in the DONE cycle.
REQ-024 done_o and we_o SHALL be low whenever done_o is not being pulsed; rd_o and wdata_o SHALL hold their last value.
REQ-025 While rdy=0, the FSM, iteration counter, datapath registers and outputs SHALL hold; cycle counts in REQ-017 and REQ-019 count only rdy-high cycles.
REQ-026 flush_i=1 SHALL force the block to IDLE at the next edge (regardless of rdy) with no done_o; a flush coincident with DONE SHALL suppress done_o and we_o in that cycle.
REQ-027 The iteration counter SHALL be clog2(XLEN)+1 bits wide and SHALL never wrap within one operation.

Reset
REQ-028 rst=0 SHALL asynchronously force state IDLE, counter 0, datapath registers 0, done_o=0, we_o=0, rd_o=0 and wdata_o=0, overriding rdy and flush_i.
REQ-029 Reset mid-operation SHALL discard the operation; the first accept after release SHALL behave as from power-up.

Verification
REQ-030 With XLEN=32 and MUL_CYCLES=2, MUL 7 x 0xFFFFFFFD, rd=5 SHALL produce done_o in cycle 2 with wdata_o=0xFFFFFFEB and we_o=1; MULHU 0xFFFFFFFF x 0xFFFFFFFF SHALL return 0xFFFFFFFE.
REQ-031 DIV 0xFFFFFFEC / 3 SHALL return 0xFFFFFFFA with done_o in cycle 33; REM on the same operands SHALL return 0xFFFFFFFE; DIVU 100/7 SHALL return 14.
REQ-032 DIVU 0x1234/0 SHALL return 0xFFFFFFFF; REM 0x1234/0 SHALL return 0x1234; DIV 0x80000000 / 0xFFFFFFFF SHALL return 0x80000000; REM on the same operands SHALL return 0; all SHALL have done_o in cycle 1.
REQ-033 flush_i pulsed in cycle 10 of a DIV SHALL produce no done_o, stall_o=0, and IDLE next cycle; a MUL presented afterwards SHALL complete normally.
REQ-034 rdy low for 5 cycles mid-DIV SHALL move done_o to cycle 38 with an unchanged result; rst pulse mid-MUL SHALL zero all outputs immediately.
REQ-035 An operation with rd=0 SHALL produce done_o=1 and we_o=0.
